// File: rtl/radius_ctrl_pkg.sv
// Shared types and defaults for the brush-radius button front end.
//   state_e : FSM states of radius_btn_ctrl
//   dir_e   : decoded button command / latched strobe direction
//   DEF_*   : default timing constants (cycles at 100 MHz)
//   cnt_width / max_u : helpers for sizing counters
// Optional feature: RADIUS_AUTO_REPEAT_EN (auto-repeat while held).
package radius_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous button level
//   btn_db     : debounced level; follows btn_raw only after the synchronised
//                level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
module btn_debounce
    import radius_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
        db_d   = db_q;
        // Any cycle of agreement restarts the stability window.
        cnt_d  = '0;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/radius_btn_ctrl.sv
// Turns two raw push buttons into one-cycle increase/decrease strobes for the
// brush-radius counter, with optional auto-repeat while a button is held.
//   clk, rst_n : clock, asynchronous active-low reset (release expected to be
//                synchronised upstream)
//   btn_up     : raw increase button, active-high, bouncy, asynchronous
//   btn_down   : raw decrease button, active-high, bouncy, asynchronous
//   increase   : registered one-cycle strobe, step radius up
//   decrease   : registered one-cycle strobe, step radius down
//   busy       : high while the FSM is outside IDLE
// Build option RADIUS_AUTO_REPEAT_EN: when defined, a held button repeats after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles; when undefined each
// press gives exactly one strobe and no repeat timer exists.
// Handshake: none; strobes are fire-and-forget, the consumer takes one step on
// every cycle a strobe is high and cannot stall this block.
module radius_btn_ctrl
    import radius_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic increase,
    output logic decrease,
    output logic busy
);

    logic up_db;
    logic dn_db;
    dir_e cmd;

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    logic   inc_q, inc_d;
    logic   dec_q, dec_d;
    logic   strobe;

`ifdef RADIUS_AUTO_REPEAT_EN
    localparam int unsigned      TMR_W       = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .btn_db  (up_db)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_down),
        .btn_db  (dn_db)
    );

    // Both buttons held decodes to no command, which also ends any hold.
    always_comb begin
        cmd = DIR_NONE;
        if (up_db && !dn_db) begin
            cmd = DIR_UP;
        end else if (dn_db && !up_db) begin
            cmd = DIR_DN;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        strobe  = 1'b0;
`ifdef RADIUS_AUTO_REPEAT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd != DIR_NONE) begin
                    state_d = FIRE;
                    dir_d   = cmd;
                end
            end
            FIRE: begin
                // The first strobe is unconditional; a release is seen in DELAY.
                strobe  = 1'b1;
                state_d = DELAY;
`ifdef RADIUS_AUTO_REPEAT_EN
                tmr_d   = '0;
`endif
            end
            DELAY: begin
                if (cmd != dir_q) begin
                    state_d = IDLE;
`ifdef RADIUS_AUTO_REPEAT_EN
                end else if (tmr_q == DELAY_LAST) begin
                    strobe  = 1'b1;
                    tmr_d   = '0;
                    state_d = REPEAT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
`endif
                end
            end
`ifdef RADIUS_AUTO_REPEAT_EN
            REPEAT: begin
                if (cmd != dir_q) begin
                    state_d = IDLE;
                end else if (tmr_q == PERIOD_LAST) begin
                    strobe = 1'b1;
                    tmr_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        inc_d = strobe && (dir_q == DIR_UP);
        dec_d = strobe && (dir_q == DIR_DN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
`ifdef RADIUS_AUTO_REPEAT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
`ifdef RADIUS_AUTO_REPEAT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    assign increase = inc_q;
    assign decrease = dec_q;
    assign busy     = (state_q != IDLE);

endmodule
